// File: rtl/mod_sched_if.sv
// Request, response and engine signal bundle for mod_sched.
// The slave side is the scheduler; the master side is the clients plus the engine.
interface mod_sched_if #(
  parameter int unsigned W       = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_result;
  logic                 rsp_div_zero;
  logic                 rsp_timeout;
  logic                 eng_start;
  logic                 eng_abort;
  logic [W-1:0]         eng_a;
  logic [W-1:0]         eng_b;
  logic                 eng_done;
  logic [W-1:0]         eng_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_div_zero, rsp_timeout,
    input  eng_start, eng_abort, eng_a, eng_b
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_div_zero, rsp_timeout,
    output eng_start, eng_abort, eng_a, eng_b
  );
endinterface

// File: rtl/mod_sched.sv
// Round-robin scheduler sharing one iterative modulo engine between NUM_REQ requesters,
// with divide-by-zero bypass and a watchdog on engine runs.
module mod_sched #(
  parameter int unsigned W       = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic        CLK,
  input logic        reset,
  mod_sched_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [IDW-1:0] id_q, id_d;
  logic           div_zero_q, div_zero_d, timeout_q, timeout_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               found;
  logic [IDW:0]       scan;
  logic [W-1:0]       a_sel, b_sel;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (!found && bus.req_valid[scan[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = bus.req_a[i*W +: W];
        b_sel = bus.req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    result_d      = result_q;
    div_zero_d    = div_zero_q;
    timeout_d     = timeout_q;
    bus.req_ready = '0;
    bus.eng_start = 1'b0;
    bus.eng_abort = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = gnt;
        if (found) begin
          a_d        = a_sel;
          b_d        = b_sel;
          id_d       = gnt_idx;
          rr_ptr_d   = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
          result_d   = '0;
          timeout_d  = 1'b0;
          div_zero_d = (b_sel == '0);
          state_d    = (b_sel == '0) ? StResp : StIssue;
        end
      end
      StIssue: begin
        bus.eng_start = 1'b1;
        timer_d       = '0;
        state_d       = StWait;
      end
      StWait: begin
        timer_d = timer_q + TW'(1);
        // Completion takes priority over the watchdog in the same cycle.
        if (bus.eng_done) begin
          result_d = bus.eng_result;
          state_d  = StResp;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          bus.eng_abort = 1'b1;
          timeout_d     = 1'b1;
          result_d      = '0;
          state_d       = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          div_zero_d = 1'b0;
          timeout_d  = 1'b0;
          result_d   = '0;
          state_d    = StIdle;
        end
      end
    endcase

    // Nothing leaves the block while reset is held, including a stray abort.
    if (reset) begin
      bus.req_ready = '0;
      bus.eng_start = 1'b0;
      bus.eng_abort = 1'b0;
    end
  end

  always_comb begin
    bus.rsp_valid    = 1'b0;
    bus.rsp_id       = '0;
    bus.rsp_result   = '0;
    bus.rsp_div_zero = 1'b0;
    bus.rsp_timeout  = 1'b0;
    bus.eng_a        = '0;
    bus.eng_b        = '0;
    if (!reset) begin
      if (state_q == StResp) begin
        bus.rsp_valid    = 1'b1;
        bus.rsp_id       = id_q;
        bus.rsp_result   = result_q;
        bus.rsp_div_zero = div_zero_q;
        bus.rsp_timeout  = timeout_q;
      end
      if (state_q == StIssue || state_q == StWait) begin
        bus.eng_a = a_q;
        bus.eng_b = b_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule
